// File: rtl/axil_pkg.sv
// Shared types, response codes and address-window helpers for the AXI4-Lite BRAM responder.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_RESP
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_DATA
    } rd_state_e;

    // Byte offset into the window, wrapped to the bus address width.
    function automatic logic [63:0] addr_offset(input logic [63:0] addr,
                                                input logic [63:0] base,
                                                input int unsigned addr_w = 32);
        logic [63:0] mask;
        mask = (addr_w >= 64) ? '1 : ((64'd1 << addr_w) - 64'd1);
        return (addr - base) & mask;
    endfunction

    function automatic logic addr_in_range(input logic [63:0] addr,
                                           input logic [63:0] base,
                                           input int unsigned depth,
                                           input int unsigned addr_w = 32);
        return addr_offset(addr, base, addr_w) < (64'(depth) << 2);
    endfunction

endpackage

// File: rtl/axil_bram_bytewe.sv
// Simple dual-port RAM, 32-bit words with per-byte write enables, synchronous read-first port.
module axil_bram_bytewe #(
    parameter  int DEPTH_WORDS = 1024,
    localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk_i,
    input  logic [3:0]       we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [31:0]      wdata_i,
    input  logic             re_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // NOTE: no reset on the array or its read register, so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (we_i[b]) begin
                mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axil_bram_responder.sv
// AXI4-Lite responder backed by a byte-writable BRAM; independent write and read channels,
// SLVERR outside the window, saturating error counter for debug.
module axil_bram_responder
    import axil_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'hA000_0000,
    parameter int                DEPTH_WORDS = 1024,
    parameter int                ERR_CNT_W   = 16
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic [ADDR_W-1:0]    S_AXI_AWADDR,
    input  logic                 S_AXI_AWVALID,
    output logic                 S_AXI_AWREADY,
    input  logic [31:0]          S_AXI_WDATA,
    input  logic [3:0]           S_AXI_WSTRB,
    input  logic                 S_AXI_WVALID,
    output logic                 S_AXI_WREADY,
    output logic [1:0]           S_AXI_BRESP,
    output logic                 S_AXI_BVALID,
    input  logic                 S_AXI_BREADY,
    input  logic [ADDR_W-1:0]    S_AXI_ARADDR,
    input  logic                 S_AXI_ARVALID,
    output logic                 S_AXI_ARREADY,
    output logic [31:0]          S_AXI_RDATA,
    output logic [1:0]           S_AXI_RRESP,
    output logic                 S_AXI_RVALID,
    input  logic                 S_AXI_RREADY,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    wr_state_e            wr_state_q, wr_state_d;
    rd_state_e            rd_state_q, rd_state_d;
    logic                 awready_q, wready_q, arready_q;
    logic [IDX_W-1:0]     w_idx_q, r_idx_q;
    logic                 w_ok_q, r_ok_q;
    logic [31:0]          w_data_q;
    logic [3:0]           w_strb_q;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
    logic [ERR_CNT_W:0]   err_sum;
    logic [1:0]           err_inc;

    logic                 aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic [IDX_W-1:0]     aw_idx, ar_idx, wr_idx_sel;
    logic                 aw_ok, ar_ok, wr_ok_sel, wr_commit;
    logic [31:0]          wr_data_sel, ram_rdata;
    logic [3:0]           wr_strb_sel, ram_we;

    assign aw_idx = IDX_W'(addr_offset(64'(S_AXI_AWADDR), 64'(BASE_ADDR), ADDR_W) >> 2);
    assign ar_idx = IDX_W'(addr_offset(64'(S_AXI_ARADDR), 64'(BASE_ADDR), ADDR_W) >> 2);
    assign aw_ok  = addr_in_range(64'(S_AXI_AWADDR), 64'(BASE_ADDR), DEPTH_WORDS, ADDR_W);
    assign ar_ok  = addr_in_range(64'(S_AXI_ARADDR), 64'(BASE_ADDR), DEPTH_WORDS, ADDR_W);

    assign aw_hs = S_AXI_AWVALID & awready_q;
    assign w_hs  = S_AXI_WVALID & wready_q;
    assign ar_hs = S_AXI_ARVALID & arready_q;
    assign b_hs  = S_AXI_BVALID & S_AXI_BREADY;
    assign r_hs  = S_AXI_RVALID & S_AXI_RREADY;

    // ---------------- write channel ----------------
    always_comb begin
        // NOTE: every always_comb output gets its default first so no path infers a latch.
        wr_state_d = wr_state_q;
        unique case (wr_state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) wr_state_d = W_RESP;
                else if (aw_hs)    wr_state_d = W_HAVE_AW;
                else if (w_hs)     wr_state_d = W_HAVE_W;
            end
            W_HAVE_AW: if (w_hs)         wr_state_d = W_RESP;
            W_HAVE_W:  if (aw_hs)        wr_state_d = W_RESP;
            W_RESP:    if (S_AXI_BREADY) wr_state_d = W_IDLE;
            default:                     wr_state_d = W_IDLE;
        endcase
    end

    // A beat arriving this cycle bypasses its holding register so the commit lands on the edge entering W_RESP.
    assign wr_idx_sel  = aw_hs ? aw_idx : w_idx_q;
    assign wr_ok_sel   = aw_hs ? aw_ok : w_ok_q;
    assign wr_data_sel = w_hs ? S_AXI_WDATA : w_data_q;
    assign wr_strb_sel = w_hs ? S_AXI_WSTRB : w_strb_q;
    assign wr_commit   = !ARESET && (wr_state_q != W_RESP) && (wr_state_d == W_RESP);
    assign ram_we      = (wr_commit && wr_ok_sel) ? wr_strb_sel : 4'b0000;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_state_q <= W_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            awready_q  <= (wr_state_d == W_IDLE) || (wr_state_d == W_HAVE_W);
            wready_q   <= (wr_state_d == W_IDLE) || (wr_state_d == W_HAVE_AW);
        end
    end

    always_ff @(posedge ACLK) begin
        if (aw_hs) begin
            w_idx_q <= aw_idx;
            w_ok_q  <= aw_ok;
        end
        if (w_hs) begin
            w_data_q <= S_AXI_WDATA;
            w_strb_q <= S_AXI_WSTRB;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = (wr_state_q == W_RESP);
    assign S_AXI_BRESP   = (S_AXI_BVALID && !w_ok_q) ? RESP_SLVERR : RESP_OKAY;

    // ---------------- read channel ----------------
    always_comb begin
        rd_state_d = rd_state_q;
        unique case (rd_state_q)
            R_IDLE:  if (ar_hs)         rd_state_d = R_FETCH;
            R_FETCH:                    rd_state_d = R_DATA;
            R_DATA:  if (S_AXI_RREADY)  rd_state_d = R_IDLE;
            default:                    rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            arready_q  <= (rd_state_d == R_IDLE);
        end
    end

    always_ff @(posedge ACLK) begin
        if (ar_hs) begin
            r_idx_q <= ar_idx;
            r_ok_q  <= ar_ok;
        end
    end

    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = (rd_state_q == R_DATA);
    assign S_AXI_RDATA   = (S_AXI_RVALID && r_ok_q) ? ram_rdata : 32'h0;
    assign S_AXI_RRESP   = (S_AXI_RVALID && !r_ok_q) ? RESP_SLVERR : RESP_OKAY;

    axil_bram_bytewe #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
        .clk_i   (ACLK),
        .we_i    (ram_we),
        .waddr_i (wr_idx_sel),
        .wdata_i (wr_data_sel),
        .re_i    (rd_state_q == R_FETCH),
        .raddr_i (r_idx_q),
        .rdata_o (ram_rdata)
    );

    // ---------------- error counter ----------------
    always_comb begin
        err_inc     = {1'b0, b_hs && !w_ok_q} + {1'b0, r_hs && !r_ok_q};
        err_sum     = {1'b0, err_count_q} + (ERR_CNT_W+1)'(err_inc);
        err_count_d = err_sum[ERR_CNT_W] ? '1 : err_sum[ERR_CNT_W-1:0];
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) err_count_q <= '0;
        else        err_count_q <= err_count_d;
    end

    assign err_count = err_count_q;

endmodule

// File: tb/tb_axil_bram_responder.sv
// Self-checking bench for axil_bram_responder: directed scenarios plus randomized traffic
// scored against a word-array model of the address window.
module tb_axil_bram_responder;

    localparam logic [31:0] BASE   = 32'hA000_0000;
    localparam int          DEPTH  = 1024;
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    logic        ACLK, ARESET;
    logic [31:0] S_AXI_AWADDR, S_AXI_WDATA, S_AXI_ARADDR, S_AXI_RDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
    logic        S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
    logic        S_AXI_RVALID, S_AXI_RREADY;
    logic [15:0] err_count;

    axil_bram_responder #(
        .ADDR_W(32), .BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .ERR_CNT_W(16)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
        .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY), .err_count(err_count)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] mem_m [DEPTH];
    bit          known_m [DEPTH];
    int          err_m = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
    endtask

    // Reference model: window membership and word index by plain offset arithmetic.
    function automatic bit in_win(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off < 32'(DEPTH * 4);
    endfunction

    function automatic int widx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'(off >> 2);
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int i;
        if (in_win(a)) begin
            i = widx(a);
            for (int b = 0; b < 4; b++)
                if (s[b]) mem_m[i][8*b +: 8] = d[8*b +: 8];
            if (s == 4'hF) known_m[i] = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int b_dly);
        bit aw_done, w_done, aw_f, w_f;
        logic [1:0] exp_r;
        aw_done = 0;
        w_done  = 0;
        exp_r   = in_win(a) ? OKAY : SLVERR;
        S_AXI_AWADDR = a;
        S_AXI_WDATA  = d;
        S_AXI_WSTRB  = s;
        for (int k = 0; k < 40 && !(aw_done && w_done); k++) begin
            S_AXI_AWVALID = !aw_done && (k >= aw_dly);
            S_AXI_WVALID  = !w_done && (k >= w_dly);
            @(negedge ACLK);
            aw_f = S_AXI_AWVALID && S_AXI_AWREADY;
            w_f  = S_AXI_WVALID && S_AXI_WREADY;
            tick();
            aw_done = aw_done | aw_f;
            w_done  = w_done | w_f;
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        check("aw_w_handshake", 32'(aw_done && w_done), 32'd1);
        for (int j = 0; j <= b_dly; j++) begin
            S_AXI_BREADY = (j == b_dly);
            @(negedge ACLK);
            check("bvalid", 32'(S_AXI_BVALID), 32'd1);
            check("bresp", 32'(S_AXI_BRESP), 32'(exp_r));
            if (j < b_dly) tick();
        end
        tick();
        S_AXI_BREADY = 1'b0;
        @(negedge ACLK);
        check("bvalid_drop", 32'(S_AXI_BVALID), 32'd0);
        check("aw_w_ready_back", 32'({S_AXI_AWREADY, S_AXI_WREADY}), 32'd3);
        tick();
        model_write(a, d, s);
        if (exp_r == SLVERR) err_m++;
    endtask

    task automatic axi_read(input logic [31:0] a, input int r_dly, output logic [31:0] got);
        bit hs, chk_d;
        logic [31:0] exp_d;
        logic [1:0] exp_r;
        hs    = 0;
        exp_r = in_win(a) ? OKAY : SLVERR;
        exp_d = in_win(a) ? mem_m[widx(a)] : 32'h0;
        chk_d = !in_win(a) || known_m[widx(a)];
        got   = 32'h0;
        S_AXI_ARADDR  = a;
        S_AXI_ARVALID = 1'b1;
        for (int k = 0; k < 40 && !hs; k++) begin
            @(negedge ACLK);
            hs = S_AXI_ARREADY;
            tick();
        end
        S_AXI_ARVALID = 1'b0;
        check("ar_handshake", 32'(hs), 32'd1);
        @(negedge ACLK);
        check("rvalid_fetch_gap", 32'(S_AXI_RVALID), 32'd0);
        tick();
        for (int j = 0; j <= r_dly; j++) begin
            S_AXI_RREADY = (j == r_dly);
            @(negedge ACLK);
            check(j == 0 ? "rvalid_latency" : "rvalid_hold", 32'(S_AXI_RVALID), 32'd1);
            check("rresp", 32'(S_AXI_RRESP), 32'(exp_r));
            if (chk_d) check("rdata", S_AXI_RDATA, exp_d);
            got = S_AXI_RDATA;
            if (j < r_dly) tick();
        end
        tick();
        S_AXI_RREADY = 1'b0;
        @(negedge ACLK);
        check("rvalid_drop", 32'(S_AXI_RVALID), 32'd0);
        check("arready_back", 32'(S_AXI_ARREADY), 32'd1);
        tick();
        if (exp_r == SLVERR) err_m++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, a;
        int sel;

        ARESET = 1'b1;
        S_AXI_AWADDR = '0; S_AXI_AWVALID = 0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0;
        S_AXI_WVALID = 0; S_AXI_BREADY = 0; S_AXI_ARADDR = '0; S_AXI_ARVALID = 0;
        S_AXI_RREADY = 0;
        for (int i = 0; i < DEPTH; i++) begin
            mem_m[i]   = 32'h0;
            known_m[i] = 1'b0;
        end

        // Reset values
        repeat (20) tick();
        @(negedge ACLK);
        check("rst_readies", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 32'd0);
        check("rst_valids", 32'({S_AXI_BVALID, S_AXI_RVALID}), 32'd0);
        check("rst_resps", 32'({S_AXI_BRESP, S_AXI_RRESP}), 32'd0);
        check("rst_rdata", S_AXI_RDATA, 32'h0);
        check("rst_err_count", 32'(err_count), 32'd0);
        tick();
        ARESET = 1'b0;
        tick();
        @(negedge ACLK);
        check("readies_after_reset", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 32'd7);
        tick();

        // 1: basic write then read-back
        axi_write(BASE, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
        axi_read(BASE, 0, d);
        check("t1_data", d, 32'hDEAD_BEEF);

        // 2: byte strobes
        axi_write(BASE + 32'h4, 32'h1122_3344, 4'hF, 0, 0, 0);
        axi_write(BASE + 32'h4, 32'hAABB_CCDD, 4'b0101, 0, 0, 0);
        axi_read(BASE + 32'h4, 0, d);
        check("t2_strobe_merge", d, 32'h11BB_33DD);

        // 3: skewed AW/W and back-pressured B
        axi_write(BASE + 32'hC, 32'h0F0F_1234, 4'hF, 0, 3, 5);
        axi_read(BASE + 32'hC, 0, d);
        axi_write(BASE + 32'h10, 32'hA5A5_5A5A, 4'hF, 3, 0, 5);
        axi_read(BASE + 32'h10, 2, d);

        // 4: window boundaries
        axi_write(BASE + 32'hFFC, 32'hCAFE_F00D, 4'hF, 0, 0, 0);
        axi_write(BASE + 32'h1000, 32'h1111_1111, 4'hF, 0, 0, 0);
        axi_write(32'h9FFF_FFFC, 32'h2222_2222, 4'hF, 1, 0, 0);
        axi_read(BASE + 32'h1000, 0, d);
        axi_read(32'h9FFF_FFFC, 1, d);
        @(negedge ACLK);
        check("t4_err_count", 32'(err_count), 32'd4);
        tick();
        axi_read(BASE, 0, d);
        check("t4_word0_untouched", d, 32'hDEAD_BEEF);
        axi_read(BASE + 32'hFFC, 0, d);
        check("t4_last_word", d, 32'hCAFE_F00D);

        // 5: read fetch and write commit on the same edge, same word
        axi_write(BASE + 32'h8, 32'h0, 4'hF, 0, 0, 0);
        S_AXI_ARADDR = BASE + 32'h8;
        S_AXI_ARVALID = 1'b1;
        @(negedge ACLK);
        check("t5_arready", 32'(S_AXI_ARREADY), 32'd1);
        tick();
        S_AXI_ARVALID = 1'b0;
        S_AXI_AWADDR = BASE + 32'h8; S_AXI_WDATA = 32'h5; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        @(negedge ACLK);
        check("t5_aw_w_ready", 32'({S_AXI_AWREADY, S_AXI_WREADY}), 32'd3);
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
        @(negedge ACLK);
        check("t5_rvalid", 32'(S_AXI_RVALID), 32'd1);
        check("t5_old_data", S_AXI_RDATA, 32'h0);
        check("t5_bvalid", 32'(S_AXI_BVALID), 32'd1);
        check("t5_bresp", 32'(S_AXI_BRESP), 32'(OKAY));
        tick();
        S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
        model_write(BASE + 32'h8, 32'h5, 4'hF);
        tick();
        axi_read(BASE + 32'h8, 0, d);
        check("t5_new_data", d, 32'h5);

        // 6: reset with the write in W_HAVE_AW and the read in R_DATA
        S_AXI_AWADDR = BASE; S_AXI_AWVALID = 1'b1;
        S_AXI_ARADDR = BASE + 32'h4; S_AXI_ARVALID = 1'b1;
        @(negedge ACLK);
        check("t6_pre_readies", 32'({S_AXI_AWREADY, S_AXI_ARREADY}), 32'd3);
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        tick();
        S_AXI_WDATA = 32'h0BAD_F00D; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        S_AXI_BREADY = 1'b1;
        ARESET = 1'b1;
        @(negedge ACLK);
        check("t6_pre_rvalid", 32'(S_AXI_RVALID), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge ACLK);
            check("t6_valids_in_reset", 32'({S_AXI_BVALID, S_AXI_RVALID}), 32'd0);
            check("t6_readies_in_reset", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 32'd0);
            check("t6_err_count", 32'(err_count), 32'd0);
        end
        tick();
        ARESET = 1'b0; S_AXI_WVALID = 1'b0;
        err_m = 0;
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            check("t6_readies_after", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 32'd7);
            check("t6_no_b_response", 32'(S_AXI_BVALID), 32'd0);
            tick();
        end
        S_AXI_BREADY = 1'b0;
        axi_read(BASE, 0, d);
        check("t6_no_commit", d, 32'hDEAD_BEEF);

        // Randomized traffic on words 16..31 plus occasional out-of-window accesses
        for (int i = 16; i < 32; i++)
            axi_write(BASE + 32'(4 * i), $urandom, 4'hF, 0, 0, 0);
        for (int n = 0; n < 80; n++) begin
            sel = int'($urandom_range(0, 5));
            if (sel == 0)
                a = BASE + 32'h1000 + 32'(4 * $urandom_range(0, 255));
            else if (sel == 1)
                a = BASE - 32'(4 * $urandom_range(1, 64));
            else
                a = BASE + 32'(4 * $urandom_range(16, 31)) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0)
                axi_write(a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            else
                axi_read(a, int'($urandom_range(0, 3)), d);
        end
        @(negedge ACLK);
        check("final_err_count", 32'(err_count), 32'(err_m));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axil_bram_responder.md
Name: axil_bram_responder

Overview:
- AXI4-Lite slave (responder) in PL, 32-bit data, word-addressed internal BRAM of DEPTH_WORDS entries.
- Completes transactions issued by the PS GP master port at BASE_ADDR (default 0xA000_0000), for example the PS write-then-read-back sanity check.
- Write and read channels are independent. Out-of-window accesses complete with SLVERR.
- A saturating error counter is exported for debug.

Parameters:
- ADDR_W, 32, AXI address width.
- BASE_ADDR, 32'hA000_0000, first byte address of the window.
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, 16..65536.
- ERR_CNT_W, 16, width of the error counter.

Ports:
- ACLK  in  1  single clock for all logic.
- ARESET  in  1  synchronous, active-high reset.
- S_AXI_AWADDR  in  ADDR_W  write address.
- S_AXI_AWVALID  in  1  write address valid.
- S_AXI_AWREADY  out  1  write address ready.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte strobes.
- S_AXI_WVALID  in  1  write data valid.
- S_AXI_WREADY  out  1  write data ready.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID  out  1  write response valid.
- S_AXI_BREADY  in  1  write response ready.
- S_AXI_ARADDR  in  ADDR_W  read address.
- S_AXI_ARVALID  in  1  read address valid.
- S_AXI_ARREADY  out  1  read address ready.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID  out  1  read data valid.
- S_AXI_RREADY  in  1  read data ready.
- err_count  out  ERR_CNT_W  count of SLVERR responses; saturates at all-ones.

Behaviour:
- Reset values (while ARESET=1): all READY outputs 0, BVALID=RVALID=0, BRESP=RRESP=2'b00, RDATA=0, err_count=0. BRAM contents are not reset.
- Cycle after ARESET falls: AWREADY=WREADY=ARREADY=1.
- Decode: off = addr - BASE_ADDR (mod 2^ADDR_W). In range iff off < DEPTH_WORDS*4. Word index = off[log2(DEPTH_WORDS)+1:2]. addr[1:0] is ignored.
- Write FSM states: W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
  - W_IDLE: AWREADY=WREADY=1. AW+W handshake in the same cycle -> W_RESP. AW only -> latch address, go W_HAVE_AW. W only -> latch data and strobes, go W_HAVE_W.
  - W_HAVE_AW: WREADY=1, AWREADY=0. W handshake -> W_RESP.
  - W_HAVE_W: AWREADY=1, WREADY=0. AW handshake -> W_RESP.
  - The BRAM write commits on the clock edge entering W_RESP, per byte lane where WSTRB[i]=1, and only if the address is in range. WSTRB=0 is a legal no-op with OKAY.
  - W_RESP: BVALID=1; BRESP=OKAY (00) if in range, else SLVERR (10). BVALID/BRESP hold stable until BREADY; BVALID&BREADY -> W_IDLE with AWREADY=WREADY=1 the next cycle.
  - Throughput: one write per 2 cycles with BREADY held high.
- Read FSM states: R_IDLE, R_FETCH, R_DATA.
  - R_IDLE: ARREADY=1. ARVALID -> latch address, go R_FETCH.
  - R_FETCH: synchronous BRAM read, 1 cycle, go R_DATA.
  - R_DATA: RVALID=1. RDATA = word if in range, else 0 with RRESP=SLVERR. RDATA/RRESP held stable until RREADY; RVALID&RREADY -> R_IDLE.
  - Latency from AR handshake to RVALID: 2 cycles.
- Read/write collision on the same word in the same edge: the read returns the pre-write (old) data. Writes are never reordered.
- err_count increments by 1 on each SLVERR response handshake (B or R). B and R SLVERR handshakes in the same cycle add 2, saturating.
- Reset mid-transaction: all in-flight state is discarded, FSMs return to idle, and no response is issued. A BRAM write that already committed stays committed.
- VALID outputs never depend combinationally on READY inputs. READY outputs are registered.

Decomposition:
- Package axil_pkg holds:
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
  - The write/read FSM state enums.
  - Function addr_in_range(addr, base, depth).
- One sub-module, axil_bram_bytewe: a simple dual-port RAM, DEPTH_WORDS x 32, 4 byte write enables, synchronous read, read-first collision behaviour.

Test Plan:
1. Reset 20 cycles, write 0xDEADBEEF to 0xA000_0000 with WSTRB=4'hF, then read 0xA000_0000 -> BRESP=00, RDATA=0xDEADBEEF, RRESP=00, RVALID exactly 2 cycles after AR handshake.
2. Write 0x11223344 to 0xA000_0004, then 0xAABBCCDD with WSTRB=4'b0101 -> readback 0x11BB33DD.
3. AWVALID 3 cycles before WVALID, and separately WVALID 3 cycles before AWVALID; hold BREADY=0 for 5 cycles -> BVALID/BRESP stable, single commit, correct readback.
4. Write and read to 0xA000_1000 (DEPTH=1024) and to 0x9FFF_FFFC -> BRESP=10, RRESP=10, RDATA=0, memory unchanged, err_count=4.
5. Same-cycle write-commit and read-fetch on 0xA000_0008 (old 0x0, new 0x5) -> read returns 0x0; subsequent read returns 0x5.
6. Assert ARESET while in W_HAVE_AW and R_DATA -> next cycle BVALID=RVALID=0, READYs 0 during reset and 1 after; no B response emitted; err_count=0.
